// File: rtl/regfile_mp.sv
// regfile_mp: multi-port GPR file with a per-register pending-write
// scoreboard used by decode to detect RAW hazards.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   rd_addr        NUM_RD packed read addresses (port i at [i*AW +: AW])
//   rd_data        NUM_RD packed read data, combinational
//   rd_pend        pending bit of each addressed register, combinational
//   wr_en/addr/data NUM_WR packed synchronous write ports
//   claim_en/addr  marks a destination register as pending
//
// Build option:
//   REGFILE_BYPASS_EN  forwards same-cycle write data to the read ports
module regfile_mp #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_pend,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR*DW-1:0] wr_data,
    input  logic                 claim_en,
    input  logic [AW-1:0]        claim_addr
);

    logic [DEPTH-1:0][DW-1:0] regs;
    logic [DEPTH-1:0]         pend;
    logic [DEPTH-1:0]         pendNext;

    function automatic logic isZero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Writebacks clear first, then a claim sets: a claim in the same
    // cycle as a writeback belongs to a newer producer and must win.
    always_comb begin
        pendNext = pend;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                pendNext[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (claim_en) begin
            pendNext[claim_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pendNext[0] = 1'b0;
        end
    end

    // Ascending port order means the higher port's NBA lands last
    // and wins an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
            pend <= '0;
        end else begin
            pend <= pendNext;
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && !isZero(wr_addr[w*AW +: AW])) begin
                    regs[wr_addr[w*AW +: AW]] <= wr_data[w*DW +: DW];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : gRd
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          pnd;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            data = regs[addr];
            pnd  = pend[addr];
`ifdef REGFILE_BYPASS_EN
            // Writes are dropped during reset, so nothing is forwarded.
            if (!rst) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
                        data = wr_data[w*DW +: DW];
                        pnd  = claim_en && (claim_addr == addr);
                    end
                end
            end
`endif
            if (isZero(addr)) begin
                data = '0;
                pnd  = 1'b0;
            end
        end

        assign rd_data[i*DW +: DW] = data;
        assign rd_pend[i]          = pnd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized bench for regfile_mp against an array model.
// u0: 32x32, 2 rd, 2 wr, zero reg; u1: 16x64, 4 rd, 1 wr, no zero reg.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Stimulus, indexed [dut][port]
    logic [1:0]  we [2];
    logic [4:0]  wa [2][2];
    logic [63:0] wd [2][2];
    logic        ce [2];
    logic [4:0]  ca [2];
    logic [4:0]  ra [2][4];

    logic [9:0]   rdAddr0;
    logic [63:0]  rdData0;
    logic [1:0]   rdPend0;
    logic [9:0]   wrAddr0;
    logic [63:0]  wrData0;
    logic [15:0]  rdAddr1;
    logic [255:0] rdData1;
    logic [3:0]   rdPend1;

    assign rdAddr0 = {ra[0][1], ra[0][0]};
    assign wrAddr0 = {wa[0][1], wa[0][0]};
    assign wrData0 = {wd[0][1][31:0], wd[0][0][31:0]};
    assign rdAddr1 = {ra[1][3][3:0], ra[1][2][3:0],
                      ra[1][1][3:0], ra[1][0][3:0]};

    regfile_mp #(
        .DW(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
    ) u0 (
        .clk(clk), .rst(rst),
        .rd_addr(rdAddr0), .rd_data(rdData0), .rd_pend(rdPend0),
        .wr_en(we[0]), .wr_addr(wrAddr0), .wr_data(wrData0),
        .claim_en(ce[0]), .claim_addr(ca[0])
    );

    regfile_mp #(
        .DW(64), .DEPTH(16), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(0)
    ) u1 (
        .clk(clk), .rst(rst),
        .rd_addr(rdAddr1), .rd_data(rdData1), .rd_pend(rdPend1),
        .wr_en(we[1][0]), .wr_addr(wa[1][0][3:0]), .wr_data(wd[1][0]),
        .claim_en(ce[1]), .claim_addr(ca[1][3:0])
    );

    // Reference state
    logic [63:0] mem [2][32];
    logic        pnd [2][32];

    int tests = 0;
    int fails = 0;

    function automatic int nRd(int k); return (k == 0) ? 2 : 4; endfunction
    function automatic int nWr(int k); return (k == 0) ? 2 : 1; endfunction
    function automatic int depth(int k); return (k == 0) ? 32 : 16; endfunction
    function automatic bit zr(int k); return (k == 0); endfunction
    function automatic logic [63:0] dmask(int k);
        return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic modelClear();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                mem[k][r] = 64'h0;
                pnd[k][r] = 1'b0;
            end
        end
    endtask

    // What one rising edge does to the architectural state.
    task automatic modelEdge();
        if (rst) return;
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < nWr(k); w++) begin
                if (we[k][w]) begin
                    if (!(zr(k) && wa[k][w] == 5'd0))
                        mem[k][wa[k][w]] = wd[k][w] & dmask(k);
                    pnd[k][wa[k][w]] = 1'b0;
                end
            end
            if (ce[k]) pnd[k][ca[k]] = 1'b1;
            if (zr(k)) pnd[k][0] = 1'b0;
        end
    endtask

    function automatic void expRead(input int k, input int p,
                                    output logic [63:0] d,
                                    output logic q);
        logic [4:0] a;
        a = ra[k][p];
        d = 64'h0;
        q = 1'b0;
        if (rst) return;
        if (zr(k) && a == 5'd0) return;
        d = mem[k][a];
        q = pnd[k][a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < nWr(k); w++) begin
            if (we[k][w] && wa[k][w] == a) begin
                d = wd[k][w] & dmask(k);
                q = ce[k] && (ca[k] == a);
            end
        end
`endif
    endfunction

    function automatic logic [63:0] actData(int k, int p);
        if (k == 0) return {32'h0, rdData0[p*32 +: 32]};
        return rdData1[p*64 +: 64];
    endfunction

    function automatic logic actPend(int k, int p);
        return (k == 0) ? rdPend0[p] : rdPend1[p];
    endfunction

    task automatic compareAll();
        logic [63:0] d;
        logic        q;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < nRd(k); p++) begin
                expRead(k, p, d, q);
                chk($sformatf("u%0d port%0d data", k, p), actData(k, p), d);
                chk($sformatf("u%0d port%0d pend", k, p),
                    64'(actPend(k, p)), 64'(q));
            end
        end
    endtask

    task automatic clearInputs();
        for (int k = 0; k < 2; k++) begin
            we[k] = 2'b00;
            ce[k] = 1'b0;
            ca[k] = 5'd0;
            for (int w = 0; w < 2; w++) begin
                wa[k][w] = 5'd0;
                wd[k][w] = 64'h0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    function automatic logic [4:0] rndAddr(int k);
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, depth(k) - 1));
    endfunction

    task automatic randomInputs();
        for (int k = 0; k < 2; k++) begin
            we[k] = 2'b00;
            for (int w = 0; w < nWr(k); w++) begin
                we[k][w] = 1'($urandom_range(0, 1));
                wa[k][w] = rndAddr(k);
                wd[k][w] = {$urandom, $urandom};
            end
            ce[k] = ($urandom_range(0, 2) == 0);
            ca[k] = rndAddr(k);
            for (int p = 0; p < nRd(k); p++) ra[k][p] = rndAddr(k);
        end
    endtask

    // Continuous check of every read port, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            compareAll();
        end
    end

    initial begin
        clearInputs();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++) ra[k][p] = 5'(p + 3);
        modelClear();
        repeat (2) step();
        chk("reset data u0", rdData0, 64'h0);
        chk("reset pend u0", 64'(rdPend0), 64'h0);
        chk("reset pend u1", 64'(rdPend1), 64'h0);
        rst = 1'b0;

        // r0 is hard-wired on u0, ordinary on u1
        we[0][0] = 1'b1;
        wd[0][0] = 64'hDEAD_BEEF;
        we[1][0] = 1'b1;
        wd[1][0] = 64'h1;
        step();
        clearInputs();
        ra[0][0] = 5'd0;
        ra[1][0] = 5'd0;
        #1;
        chk("u0 r0 stays zero", actData(0, 0), 64'h0);
        chk("u1 r0 writable", actData(1, 0), 64'h1);

        // basic write, read on both ports
        we[0][0] = 1'b1;
        wa[0][0] = 5'd5;
        wd[0][0] = 64'h1234_5678;
        ra[0][0] = 5'd5;
        ra[0][1] = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("r5 bypass", actData(0, 1), 64'h1234_5678);
`endif
        step();
        clearInputs();
        #1;
        chk("r5 port0", actData(0, 0), 64'h1234_5678);
        chk("r5 port1", actData(0, 1), 64'h1234_5678);

        // collision: higher port wins
        we[0] = 2'b11;
        wa[0][0] = 5'd7;
        wa[0][1] = 5'd7;
        wd[0][0] = 64'hAAAA;
        wd[0][1] = 64'hBBBB;
        step();
        clearInputs();
        ra[0][0] = 5'd7;
        #1;
        chk("r7 collision", actData(0, 0), 64'hBBBB);

        // scoreboard
        ra[0][0] = 5'd9;
        ce[0] = 1'b1;
        ca[0] = 5'd9;
        step();
        clearInputs();
        #1;
        chk("r9 claimed", 64'(rdPend0[0]), 64'h1);
        we[0][0] = 1'b1;
        wa[0][0] = 5'd9;
        wd[0][0] = 64'h99;
        step();
        clearInputs();
        #1;
        chk("r9 written back", 64'(rdPend0[0]), 64'h0);
        we[0][0] = 1'b1;
        wa[0][0] = 5'd9;
        ce[0] = 1'b1;
        ca[0] = 5'd9;
        step();
        clearInputs();
        #1;
        chk("r9 claim beats write", 64'(rdPend0[0]), 64'h1);

        // claim then asynchronous reset before writeback
        ra[0][0] = 5'd3;
        ra[0][1] = 5'd5;
        ce[0] = 1'b1;
        ca[0] = 5'd3;
        step();
        clearInputs();
        #1;
        chk("r3 claimed", 64'(rdPend0[0]), 64'h1);
        #1;
        rst = 1'b1;
        modelClear();
        #1;
        chk("async rst pend", 64'(rdPend0[0]), 64'h0);
        chk("async rst data", actData(0, 1), 64'h0);
        we[0][0] = 1'b1;
        wa[0][0] = 5'd3;
        wd[0][0] = 64'h55;
        ce[0] = 1'b1;
        ca[0] = 5'd3;
        step();
        clearInputs();
        rst = 1'b0;
        #1;
        chk("write in rst ignored", actData(0, 0), 64'h0);
        chk("claim in rst ignored", 64'(rdPend0[0]), 64'h0);

        // u1: four ports, four independent addresses
        for (int i = 0; i < 4; i++) begin
            we[1][0] = 1'b1;
            wa[1][0] = 5'(i + 1);
            wd[1][0] = 64'h0123_4567_89AB_0000 + 64'(i);
            step();
        end
        clearInputs();
        for (int p = 0; p < 4; p++) ra[1][p] = 5'(4 - p);
        #1;
        chk("u1 port0 r4", actData(1, 0), 64'h0123_4567_89AB_0003);
        chk("u1 port1 r3", actData(1, 1), 64'h0123_4567_89AB_0002);
        chk("u1 port2 r2", actData(1, 2), 64'h0123_4567_89AB_0001);
        chk("u1 port3 r1", actData(1, 3), 64'h0123_4567_89AB_0000);

        // random traffic with occasional asynchronous resets
        repeat (3000) begin
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                modelClear();
            end
            randomInputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with an integrated pending-write scoreboard, the next-generation general-purpose register file for the pipelined MIPS core. It provides NUM_RD asynchronous read ports and NUM_WR synchronous write ports, with an optional hard-wired zero register. Per-register pending bits let decode detect RAW hazards: a bit is set when an instruction claims a destination and cleared when that register is written back. An optional same-cycle write-to-read bypass is selected at compile time.

## Interface
- DW, 32, data width in bits
- DEPTH, 32, number of registers; power of two, ≥ 2
- AW, $clog2(DEPTH), address width
- NUM_RD, 2, read port count, 1–4
- NUM_WR, 1, write port count, 1–2
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never pending
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NUM_RD*DW  read data; port i occupies bits [i*DW +: DW]
- rd_pend  out  NUM_RD  pending bit of the register addressed by each read port
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  write addresses
- wr_data  in  NUM_WR*DW  write data
- claim_en  in  1  mark claim_addr as pending
- claim_addr  in  AW  destination register being claimed

## Operation
- Storage is DEPTH×DW. Reset clears every register and every pending bit to 0 immediately, independent of clk. While rst is high, all writes and claims are ignored.
- Reads are combinational: rd_data[i] = reg[rd_addr[i]] and rd_pend[i] = pend[rd_addr[i]].
- Writes: on a rising edge, each port w with wr_en[w] writes wr_data[w] to reg[wr_addr[w]].
- Write collision: if both ports target the same address, the higher port index wins.
- Zero register: when ZERO_REG=1, writes to address 0 are dropped, reading address 0 returns 0 and rd_pend for address 0 is 0. When ZERO_REG=0, address 0 is an ordinary register.
- Scoreboard, per register r on each rising edge, evaluated in this order:
  - pend[r] clears if any wr_en[w] targets r.
  - pend[r] then sets if claim_en is high and claim_addr == r.
- A claim and a write to the same register in the same cycle leave pend = 1. The claim wins because it represents a newer producer.
- Claiming an already-pending register keeps it pending; no count is kept.
- Claiming address 0 has no effect when ZERO_REG=1.

## Timing
- Read latency is zero cycles (combinational from rd_addr to rd_data and rd_pend).
- A write at edge N is visible on the read ports after edge N. Same-cycle visibility depends on REGFILE_BYPASS_EN.
- A claim at edge N makes rd_pend high after edge N.
- A write at edge N makes rd_pend low after edge N, unless a claim to the same register occurs at the same edge.
- Reset outputs: rd_data is all zeros and rd_pend is all zeros, for any address.
- Deasserting rst mid-operation: the first edge after deassertion processes writes and claims normally.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If any active write port targets rd_addr[i], rd_data[i] returns that wr_data combinationally in the same cycle. The highest-index matching port wins.
  - rd_pend[i] is forced to 0 in that case, unless claim_en targets the same address.
  - Bypass is never applied to address 0 when ZERO_REG=1.
- REGFILE_BYPASS_EN undefined: reads always return stored contents and stored pending bits. The decode stage handles the one-cycle gap.

## Test plan
- Reset and zero register: assert rst mid-run → all 32 regs read 0 and rd_pend = 0; write 0xDEADBEEF to r0 → r0 still reads 0.
- Basic write/read: write 0x12345678 to r5 at edge N, read r5 on both ports → 0x12345678 after edge N. With REGFILE_BYPASS_EN, the value also appears in cycle N.
- Dual-write collision (NUM_WR=2): port0 writes 0xAAAA to r7 and port1 writes 0xBBBB to r7 in the same cycle → r7 = 0xBBBB.
- Scoreboard: claim r9 → rd_pend for r9 = 1 on the next cycle; write r9 → 0 on the following cycle; claim and write r9 in the same cycle → stays 1.
- Claim/reset race: claim r3, assert rst asynchronously before writeback → rd_pend 0 immediately; write and claim during rst → ignored.
- Parameter sweep: DW=64, DEPTH=16, NUM_RD=4, ZERO_REG=0 → r0 is writable (write 0x1 reads back 0x1); all four ports read independent addresses correctly.
